// File: rtl/fs8_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package fs8_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs8_serial_if.sv
// Request/response bundle of the serial subtractor: operands and start in, status and result out.
interface fs8_serial_if
    import fs8_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             Bo;

    modport master (output start, A, B, Bi, input busy, done, Y, Bo);
    modport slave  (input start, A, B, Bi, output busy, done, Y, Bo);

endinterface

// File: rtl/fs8_serial_fs1_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module fs1_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/fs8_serial.sv
// Bit-serial subtractor Y = A - B - Bi, LSB first, one bit per clock, with start/busy/done handshake.
module fs8_serial
    import fs8_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    fs8_serial_if.slave  bus
);

    localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] y_q;
    logic             bo_q;

    logic             diff_d;
    logic             brw_d;
    logic [WIDTH-1:0] res_d;

    fs1_bit u_fs1_bit (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (brw_q),
        .d_o    (diff_d),
        .bout_o (brw_d)
    );

    // The new difference bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    assign res_d = {diff_d, res_q[WIDTH-1:1]};

    // NOTE: every flop here updates with <= so all reads in this block see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            bo_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        brw_q   <= bus.Bi;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    brw_q <= brw_d;
                    res_q <= res_d;
                    if (cnt_q == LAST_CNT) begin
                        y_q     <= res_d;
                        bo_q    <= brw_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Y    = y_q;
    assign bus.Bo   = bo_q;

endmodule

// File: tb/tb_fs8_serial.sv
// Scoreboard bench for fs8_serial: directed cases, reset abort, ignored start, and 256 random subtractions.
module tb_fs8_serial;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] y;
        logic         bo;
    } exp_t;

    logic clk;
    logic reset_n;

    fs8_serial_if #(.WIDTH(W)) bus ();

    fs8_serial #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    exp_t         sb_q[$];
    logic [W-1:0] last_y  = '0;
    logic         last_bo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (Error)", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, negative result means a borrow out.
    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t e;
        int   diff;
        diff = int'(a) - int'(b) - int'(bi);
        e.a  = a;
        e.b  = b;
        e.bi = bi;
        e.bo = (diff < 0);
        e.y  = W'((diff + (1 << W)) % (1 << W));
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t         e;
                logic [W:0]   fa;
                e  = sb_q.pop_front();
                check("Y", 32'(bus.Y), 32'(e.y));
                check("Bo", 32'(bus.Bo), 32'(e.bo));
                fa = {1'b0, bus.Y} + {1'b0, e.b} + (W+1)'(e.bi);
                check("fa8_sum", 32'(fa[W-1:0]), 32'(e.a));
                check("fa8_co", 32'(fa[W]), 32'(bus.Bo));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bi    = bi;
        push_expected(a, b, bi);
    endtask

    // Finish the handshake after issue(); returns at the negedge of the DONE cycle.
    task automatic finish_op(input logic disturb);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e = sb_q[sb_q.size() - 1];
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            if (disturb && i == 3) begin
                bus.start = 1'b1;
                bus.A     = ~e.a;
                bus.B     = e.b ^ 8'h5A;
                bus.Bi    = ~e.bi;
            end else if (disturb && i == 4) begin
                bus.start = 1'b0;
                bus.A     = W'($urandom_range(0, 255));
                bus.B     = W'($urandom_range(0, 255));
            end
            if (i <= W) begin
                check("busy_shift", 32'(bus.busy), 32'd1);
                check("done_early", 32'(bus.done), 32'd0);
                check("Y_held", 32'(bus.Y), 32'(last_y));
                check("Bo_held", 32'(bus.Bo), 32'(last_bo));
            end else begin
                check("done_latency", 32'(bus.done), 32'd1);
                check("busy_done", 32'(bus.busy), 32'd0);
            end
        end
        bus.start = 1'b0;
        last_y    = e.y;
        last_bo   = e.bo;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input logic disturb);
        @(posedge clk);
        #1;
        issue(a, b, bi);
        finish_op(disturb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bi    = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_Y", 32'(bus.Y), 32'd0);
        check("rst_Bo", 32'(bus.Bo), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, 1'b0);

        // Back-to-back: second request is raised during the DONE cycle.
        run_op(8'h80, 8'h7F, 1'b1, 1'b0);
        issue(8'h10, 8'h01, 1'b0);
        finish_op(1'b0);

        // Stray start and operand changes mid-operation are ignored.
        run_op(8'hC3, 8'h4E, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Reset at cycle 4 of an operation aborts it silently.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.A     = 8'h9A;
        bus.B     = 8'h21;
        bus.Bi    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_Y", 32'(bus.Y), 32'd0);
        check("abort_Bo", 32'(bus.Bo), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        last_y  = '0;
        last_bo = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(bus.done), 32'd0);
        end

        for (int i = 0; i < 256; i++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), (i >= 128), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
